// File: rtl/grid_pkg.sv
// Shared types and constants for the kitchen object grid and its access arbiter.
package grid_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 13;

  typedef logic [3:0] cell_t;
  localparam cell_t EMPTY = 4'h0;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    PICK  = 2'd1,
    PLACE = 2'd2,
    CHOP  = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef cell_t [ROWS-1:0][COLS-1:0] grid_t;

  // Ingredient crates in the corners plus a centre item; everything else starts empty.
  function automatic grid_t default_map();
    grid_t m;
    m = '0;
    m[0][0]  = 4'h1;
    m[0][12] = 4'h2;
    m[7][0]  = 4'h3;
    m[7][12] = 4'h4;
    m[3][6]  = 4'h5;
    return m;
  endfunction

  localparam grid_t DEFAULT_MAP = default_map();

endpackage

// File: rtl/grid_access_arbiter_rr_pick.sv
// Combinational round-robin selector. GRID_ARB_FIXED0_EN gives requester 0 absolute priority.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [1:0]         id,
  output logic               any
);

  logic [1:0]  idx;
  int unsigned base;

  always_comb begin
    winner = '0;
    id     = '0;
    any    = 1'b0;
    idx    = '0;
    base   = 0;
`ifdef GRID_ARB_FIXED0_EN
    if (req[0]) begin
      winner[0] = 1'b1;
      any       = 1'b1;
    end else begin
      // Rotate over 1..NUM_REQ-1 only; a pointer of 0 is treated as 1.
      base = (ptr == 2'd0) ? 1 : 32'(ptr);
      for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
        idx = 2'(1 + ((base - 1 + i) % (NUM_REQ - 1)));
        if (!any && req[idx]) begin
          winner[idx] = 1'b1;
          id          = idx;
          any         = 1'b1;
        end
      end
    end
`else
    base = 32'(ptr);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 2'((base + i) % NUM_REQ);
      if (!any && req[idx]) begin
        winner[idx] = 1'b1;
        id          = idx;
        any         = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/grid_access_arbiter.sv
// Owns the kitchen grid; serialises atomic read-check-write ops from NUM_REQ requesters.
// Optional macro GRID_ARB_FIXED0_EN: requester 0 always wins when requesting.
module grid_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ROWS    = grid_pkg::ROWS,
  parameter int unsigned COLS    = grid_pkg::COLS
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic                             load_map,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0][1:0]          op,
  input  logic [NUM_REQ-1:0][2:0]          row,
  input  logic [NUM_REQ-1:0][3:0]          col,
  input  logic [NUM_REQ-1:0][3:0]          wdata,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             resp_valid,
  output logic [1:0]                       resp_id,
  output logic                             resp_ok,
  output logic [3:0]                       resp_data,
  output logic [ROWS-1:0][COLS-1:0][3:0]   grid_out,
  output logic                             busy
);

  import grid_pkg::*;

  arb_state_t state, state_nxt;

  logic [ROWS-1:0][COLS-1:0][3:0] grid;
  logic [1:0]   rr_ptr, ptr_nxt;
  logic         load_pending;
  logic [1:0]   lat_id;
  op_t          lat_op;
  logic [2:0]   lat_row;
  logic [3:0]   lat_col;
  cell_t        lat_wdata;

  logic [NUM_REQ-1:0] pick_winner;
  logic [1:0]         pick_id;
  logic               pick_any;
  logic               do_load, do_grant;

  logic        in_range, ok, wr;
  cell_t       cur, new_cell;
  int unsigned ptr_tmp;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (pick_winner),
    .id     (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_grant  = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_map || load_pending) begin
          do_load = 1'b1;
        end else if (enable && pick_any) begin
          do_grant  = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_tmp = (32'(pick_id) + 1) % NUM_REQ;
`ifdef GRID_ARB_FIXED0_EN
    // Serving requester 0 leaves the rotation among 1..NUM_REQ-1 untouched.
    if (pick_id == 2'd0) begin
      ptr_nxt = rr_ptr;
    end else begin
      ptr_nxt = (ptr_tmp == 0) ? 2'd1 : 2'(ptr_tmp);
    end
`else
    ptr_nxt = 2'(ptr_tmp);
`endif
  end

  always_comb begin
    in_range = (32'(lat_row) < ROWS) && (32'(lat_col) < COLS);
    cur      = in_range ? grid[lat_row][lat_col] : EMPTY;
    ok       = 1'b0;
    new_cell = cur;
    unique case (lat_op)
      READ:  ok = 1'b1;
      PICK: begin
        ok       = (cur != EMPTY);
        new_cell = EMPTY;
      end
      PLACE: begin
        ok       = (cur == EMPTY) && (lat_wdata != EMPTY);
        new_cell = lat_wdata;
      end
      CHOP: begin
        ok       = (cur != EMPTY) && !cur[3];
        new_cell = {1'b1, cur[2:0]};
      end
      default: ok = 1'b0;
    endcase
    if (!in_range) ok = 1'b0;
    wr = ok && (lat_op != READ);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grid         <= '0;
      rr_ptr       <= '0;
      load_pending <= 1'b0;
      grant        <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= '0;
      resp_ok      <= 1'b0;
      resp_data    <= '0;
      lat_id       <= '0;
      lat_op       <= READ;
      lat_row      <= '0;
      lat_col      <= '0;
      lat_wdata    <= '0;
    end else begin
      grant      <= do_grant ? pick_winner : '0;
      resp_valid <= (state == EXEC);
      if (do_grant) begin
        lat_id    <= pick_id;
        lat_op    <= op_t'(op[pick_id]);
        lat_row   <= row[pick_id];
        lat_col   <= col[pick_id];
        lat_wdata <= wdata[pick_id];
        rr_ptr    <= ptr_nxt;
      end
      if (do_load) begin
        grid         <= DEFAULT_MAP;
        load_pending <= 1'b0;
      end else if (load_map && state != IDLE) begin
        load_pending <= 1'b1;
      end
      if (state == EXEC) begin
        resp_id   <= lat_id;
        resp_ok   <= ok;
        resp_data <= cur;
        if (wr) grid[lat_row][lat_col] <= new_cell;
      end
    end
  end

  assign grid_out = grid;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed self-checking bench for grid_access_arbiter.
module tb_grid_access_arbiter;

  logic                   clock;
  logic                   reset_n;
  logic                   enable;
  logic                   load_map;
  logic [3:0]             req;
  logic [3:0][1:0]        op;
  logic [3:0][2:0]        row;
  logic [3:0][3:0]        col;
  logic [3:0][3:0]        wdata;
  logic [3:0]             grant;
  logic                   resp_valid;
  logic [1:0]             resp_id;
  logic                   resp_ok;
  logic [3:0]             resp_data;
  logic [7:0][12:0][3:0]  grid_out;
  logic                   busy;

  int unsigned passed;
  int unsigned total;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PICK  = 2'd1;
  localparam logic [1:0] OP_PLACE = 2'd2;
  localparam logic [1:0] OP_CHOP  = 2'd3;

  grid_access_arbiter #(.NUM_REQ(4), .ROWS(8), .COLS(13)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .load_map   (load_map),
    .req        (req),
    .op         (op),
    .row        (row),
    .col        (col),
    .wdata      (wdata),
    .grant      (grant),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_ok    (resp_ok),
    .resp_data  (resp_data),
    .grid_out   (grid_out),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] cell_at(input logic [2:0] r, input logic [3:0] c);
    return grid_out[r][c];
  endfunction

  // Issue one op from an idle arbiter, check the fixed-latency response, then release req.
  task automatic run_op(input string tag, input logic [1:0] id, input logic [1:0] o,
                        input logic [2:0] r, input logic [3:0] c, input logic [3:0] w,
                        input logic exp_ok, input logic [3:0] exp_data);
    logic [3:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    op[id] = o; row[id] = r; col[id] = c; wdata[id] = w; req[id] = 1'b1;
    step();
    check({tag, ".grant"}, 32'(grant), 32'(oh));
    step();
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".id"},    32'(resp_id),    32'(id));
    check({tag, ".ok"},    32'(resp_ok),    32'(exp_ok));
    check({tag, ".data"},  32'(resp_data),  32'(exp_data));
    req[id] = 1'b0;
    step();
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    passed = 0; total = 0;
    reset_n = 1'b0; enable = 1'b1; load_map = 1'b0;
    req = '0; op = '0; row = '0; col = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.grant", 32'(grant),      32'd0);
    check("rst.valid", 32'(resp_valid), 32'd0);
    check("rst.id",    32'(resp_id),    32'd0);
    check("rst.ok",    32'(resp_ok),    32'd0);
    check("rst.data",  32'(resp_data),  32'd0);
    check("rst.busy",  32'(busy),       32'd0);
    check("rst.grid",  32'(|grid_out),  32'd0);
    reset_n = 1'b1;
    step();

    // Place then observe the write; ptr ends at 2.
    run_op("t1", 2'd1, OP_PLACE, 3'd2, 4'd3, 4'd5, 1'b1, 4'd0);
    check("t1.cell", 32'(cell_at(3'd2, 4'd3)), 32'd5);
    check("t1.idle", 32'(busy), 32'd0);

    // Requester 3 moves ptr to 0, then 0 and 2 race for the same cell.
    run_op("t2.pre", 2'd3, OP_READ, 3'd0, 4'd0, 4'd0, 1'b1, 4'd0);
    op[0] = OP_PICK; row[0] = 3'd2; col[0] = 4'd3; req[0] = 1'b1;
    op[2] = OP_PICK; row[2] = 3'd2; col[2] = 4'd3; req[2] = 1'b1;
    step();
    check("t2.g0", 32'(grant), 32'h1);
    step();
    check("t2.id0",   32'(resp_id),   32'd0);
    check("t2.ok0",   32'(resp_ok),   32'd1);
    check("t2.data0", 32'(resp_data), 32'd5);
    check("t2.cell",  32'(cell_at(3'd2, 4'd3)), 32'd0);
    req[0] = 1'b0;
    step();
    step();
    check("t2.g2", 32'(grant), 32'h4);
    step();
    check("t2.v2",    32'(resp_valid), 32'd1);
    check("t2.id2",   32'(resp_id),    32'd2);
    check("t2.ok2",   32'(resp_ok),    32'd0);
    check("t2.data2", 32'(resp_data),  32'd0);
    req[2] = 1'b0;
    step();

    // All four held; ptr is 3 here.
`ifdef GRID_ARB_FIXED0_EN
    rr_exp = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
    rr_exp = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
`endif
    for (int i = 0; i < 4; i++) begin
      op[i] = OP_READ; row[i] = 3'd0; col[i] = 4'd0;
    end
    req = 4'hF;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k % 3 == 1) check($sformatf("t3.g%0d", k), 32'(grant), 32'(rr_exp[k / 3]));
      else            check($sformatf("t3.g%0d", k), 32'(grant), 32'd0);
    end
    req = '0;
    step();
    check("t3.idle", 32'(busy), 32'd0);

    // Op-specific success/failure rules and out-of-range handling.
    run_op("t4.place", 2'd0, OP_PLACE, 3'd1, 4'd1, 4'd3, 1'b1, 4'd3 & 4'd0);
    run_op("t4.chop1", 2'd0, OP_CHOP,  3'd1, 4'd1, 4'd0, 1'b1, 4'd3);
    check("t4.cellB", 32'(cell_at(3'd1, 4'd1)), 32'hB);
    run_op("t4.chop2", 2'd0, OP_CHOP,  3'd1, 4'd1, 4'd0, 1'b0, 4'hB);
    check("t4.cellB2", 32'(cell_at(3'd1, 4'd1)), 32'hB);
    run_op("t4.occ",   2'd0, OP_PLACE, 3'd1, 4'd1, 4'd2, 1'b0, 4'hB);
    run_op("t4.oor",   2'd0, OP_PLACE, 3'd4, 4'd13, 4'd7, 1'b0, 4'd0);
    run_op("t4.zero",  2'd0, OP_PLACE, 3'd4, 4'd4, 4'd0, 1'b0, 4'd0);
    run_op("t4.pick0", 2'd0, OP_PICK,  3'd4, 4'd4, 4'd0, 1'b0, 4'd0);
    run_op("t4.read",  2'd0, OP_READ,  3'd1, 4'd1, 4'd0, 1'b1, 4'hB);

    // load_map during EXEC is deferred until the arbiter is idle again.
    op[1] = OP_READ; row[1] = 3'd1; col[1] = 4'd1; req[1] = 1'b1;
    step();
    check("t5.grant", 32'(grant), 32'h2);
    load_map = 1'b1;
    step();
    load_map = 1'b0;
    check("t5.ok",   32'(resp_ok),   32'd1);
    check("t5.data", 32'(resp_data), 32'hB);
    check("t5.pre",  32'(cell_at(3'd1, 4'd1)), 32'hB);
    req[1] = 1'b0;
    step();
    check("t5.nogr", 32'(grant), 32'd0);
    step();
    check("t5.m00",  32'(cell_at(3'd0, 4'd0)),  32'h1);
    check("t5.m012", 32'(cell_at(3'd0, 4'd12)), 32'h2);
    check("t5.m70",  32'(cell_at(3'd7, 4'd0)),  32'h3);
    check("t5.m712", 32'(cell_at(3'd7, 4'd12)), 32'h4);
    check("t5.m36",  32'(cell_at(3'd3, 4'd6)),  32'h5);
    check("t5.m11",  32'(cell_at(3'd1, 4'd1)),  32'h0);

    // Grants blocked while disabled; load_map still honoured.
    run_op("t5.pick", 2'd3, OP_PICK, 3'd3, 4'd6, 4'd0, 1'b1, 4'h5);
    enable = 1'b0;
    op[2] = OP_READ; row[2] = 3'd7; col[2] = 4'd0; req[2] = 1'b1;
    load_map = 1'b1;
    step();
    load_map = 1'b0;
    check("t5.dis0", 32'(grant), 32'd0);
    step();
    check("t5.reload", 32'(cell_at(3'd3, 4'd6)), 32'h5);
    check("t5.dis1", 32'(grant), 32'd0);
    step();
    check("t5.dis2", 32'(grant), 32'd0);
    step();
    check("t5.dis3", 32'(grant), 32'd0);
    check("t5.disb", 32'(busy),  32'd0);
    enable = 1'b1;
    step();
    check("t5.en.grant", 32'(grant), 32'h4);
    step();
    check("t5.en.ok",   32'(resp_ok),   32'd1);
    check("t5.en.data", 32'(resp_data), 32'h3);
    req[2] = 1'b0;
    step();

    // Reset asserted while an op is executing.
    op[1] = OP_PLACE; row[1] = 3'd0; col[1] = 4'd5; wdata[1] = 4'd6; req[1] = 1'b1;
    step();
    check("t6.grant", 32'(grant), 32'h2);
    reset_n = 1'b0;
    #1;
    check("t6.gr0",  32'(grant),      32'd0);
    check("t6.busy", 32'(busy),       32'd0);
    check("t6.grid", 32'(|grid_out),  32'd0);
    step();
    check("t6.nov",  32'(resp_valid), 32'd0);
    req[1] = 1'b0;
    reset_n = 1'b1;
    step();
    check("t6.nov2", 32'(resp_valid), 32'd0);
    check("t6.cell", 32'(cell_at(3'd0, 4'd5)), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
